// File: rtl/dft64_sample_packer_if.sv
// Sample-in / beat-out bundle shared by the packer and its upstream/downstream partners.
// master: upstream sample source plus dft64 ready; slave: the packer itself.
interface dft64_sample_packer_if;
   logic         s_valid;
   logic [15:0]  s_data;
   logic         s_ready;
   logic         dft_ready;
   logic [127:0] samples;
   logic         rel;
   logic         calculate;
   logic         sof;

   modport master (
      output s_valid, s_data, dft_ready,
      input  s_ready, samples, rel, calculate, sof
   );

   modport slave (
      input  s_valid, s_data, dft_ready,
      output s_ready, samples, rel, calculate, sof
   );
endinterface

// File: rtl/dft64_sample_packer.sv
// Ping-pong packer: collects 64 Q8.8 samples per bank and streams each bank to dft64 as 8 beats of 8.
// Optional stall counter port enabled by defining DFT64_PACK_STALL_CNT_EN.
module dft64_sample_packer (
   input logic                  clk,
   input logic                  sreset,
   dft64_sample_packer_if.slave bus
`ifdef DFT64_PACK_STALL_CNT_EN
   ,
   output logic [15:0]          stall_cnt
`endif
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   logic [15:0]  mem_r [0:127];
   logic [5:0]   wr_idx_r;
   logic         wr_bank_r;
   logic         rd_bank_r;
   logic [1:0]   full_r;
   state_t       state_r;
   logic [2:0]   beat_r;
   logic [127:0] samples_r;
   logic         rel_r;
   logic         sof_r;

   logic         accept_s;
   logic         last_s;
   logic [1:0]   set_mask_s;
   logic [1:0]   clr_mask_s;
   logic         other_bank_s;
   logic         rd_full_s;
   logic         other_full_s;
   logic         end_s;
   logic         start_s;
   logic         chain_s;
   logic         rd_sel_s;
   logic [2:0]   beat_sel_s;
   logic [127:0] beat_data_s;

   assign bus.s_ready   = ~full_r[wr_bank_r];
   assign bus.samples   = samples_r;
   assign bus.rel       = rel_r;
   assign bus.calculate = rel_r;
   assign bus.sof       = sof_r;

   // Handshake decode and full-flag set/clear masks
   always_comb begin
      accept_s     = bus.s_valid && bus.s_ready;
      last_s       = accept_s && (wr_idx_r == 6'd63);
      other_bank_s = ~rd_bank_r;
      end_s        = (state_r == BURST) && (beat_r == 3'd7);
      if (last_s) begin
         set_mask_s = wr_bank_r ? 2'b10 : 2'b01;
      end else begin
         set_mask_s = 2'b00;
      end
      if (end_s) begin
         clr_mask_s = rd_bank_r ? 2'b10 : 2'b01;
      end else begin
         clr_mask_s = 2'b00;
      end
      // A bank completing on this very edge counts as full, giving 1-cycle latency
      rd_full_s    = full_r[rd_bank_r] || set_mask_s[rd_bank_r];
      other_full_s = full_r[other_bank_s] || set_mask_s[other_bank_s];
      start_s      = (state_r == IDLE) && bus.dft_ready && rd_full_s;
      chain_s      = end_s && bus.dft_ready && other_full_s;
   end

   // Select which bank/beat the output register loads on this edge
   always_comb begin
      rd_sel_s   = rd_bank_r;
      beat_sel_s = 3'd0;
      case (state_r)
         IDLE: begin
            rd_sel_s   = rd_bank_r;
            beat_sel_s = 3'd0;
         end
         BURST: begin
            if (beat_r == 3'd7) begin
               rd_sel_s   = other_bank_s;
               beat_sel_s = 3'd0;
            end else begin
               rd_sel_s   = rd_bank_r;
               beat_sel_s = beat_r + 3'd1;
            end
         end
         default: begin
            rd_sel_s   = rd_bank_r;
            beat_sel_s = 3'd0;
         end
      endcase
   end

   // Gather eight consecutive samples, oldest in the top lane
   always_comb begin
      beat_data_s = 128'd0;
      for (int k = 0; k < 8; k++) begin
         beat_data_s[16*(7-k) +: 16] = mem_r[{rd_sel_s, beat_sel_s, 3'(k)}];
      end
   end

   // Sample storage, two banks of 64
   always_ff @(posedge clk) begin
      if (accept_s && !sreset) begin
         mem_r[{wr_bank_r, wr_idx_r}] <= bus.s_data;
      end
   end

   // Write index, write bank and full flags
   always_ff @(posedge clk) begin
      if (sreset) begin
         wr_idx_r  <= 6'd0;
         wr_bank_r <= 1'b0;
         full_r    <= 2'b00;
      end else begin
         full_r <= (full_r & ~clr_mask_s) | set_mask_s;
         if (accept_s) begin
            wr_idx_r <= wr_idx_r + 6'd1;
         end
         if (last_s) begin
            wr_bank_r <= ~wr_bank_r;
         end
      end
   end

   // Burst FSM with registered beat outputs
   always_ff @(posedge clk) begin
      if (sreset) begin
         state_r   <= IDLE;
         beat_r    <= 3'd0;
         rd_bank_r <= 1'b0;
         samples_r <= 128'd0;
         rel_r     <= 1'b0;
         sof_r     <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start_s) begin
                  state_r   <= BURST;
                  beat_r    <= 3'd0;
                  samples_r <= beat_data_s;
                  rel_r     <= 1'b1;
                  sof_r     <= 1'b1;
               end else begin
                  rel_r <= 1'b0;
                  sof_r <= 1'b0;
               end
            end
            BURST: begin
               if (end_s) begin
                  rd_bank_r <= other_bank_s;
                  if (chain_s) begin
                     beat_r    <= 3'd0;
                     samples_r <= beat_data_s;
                     rel_r     <= 1'b1;
                     sof_r     <= 1'b1;
                  end else begin
                     state_r <= IDLE;
                     rel_r   <= 1'b0;
                     sof_r   <= 1'b0;
                  end
               end else begin
                  beat_r    <= beat_r + 3'd1;
                  samples_r <= beat_data_s;
                  rel_r     <= 1'b1;
                  sof_r     <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               rel_r   <= 1'b0;
               sof_r   <= 1'b0;
            end
         endcase
      end
   end

`ifdef DFT64_PACK_STALL_CNT_EN
   // Saturating count of cycles the source was held off
   always_ff @(posedge clk) begin
      if (sreset) begin
         stall_cnt <= 16'd0;
      end else if (bus.s_valid && !bus.s_ready && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dft64_sample_packer.sv
// Scoreboard bench for dft64_sample_packer: accepted samples are queued, each rel beat pops eight.
module tb_dft64_sample_packer;
   logic clk;
   logic sreset;
   int   n_tests;
   int   n_fail;
   int   tb_beat;
   logic [15:0] sb_q [$];

   dft64_sample_packer_if bus ();
`ifdef DFT64_PACK_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   dft64_sample_packer dut (
      .clk       (clk),
      .sreset    (sreset),
      .bus       (bus)
`ifdef DFT64_PACK_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Output monitor: compares beats against the queue, then records this cycle's accept/reset
   always @(negedge clk) begin
      logic [127:0] exp;
      if (bus.rel) begin
         exp = 128'd0;
         if (sb_q.size() < 8) begin
            chk("sb_underflow", 128'(sb_q.size()), 128'd8);
         end else begin
            for (int k = 0; k < 8; k++) exp[16*(7-k) +: 16] = sb_q.pop_front();
            chk("beat_data", bus.samples, exp);
         end
         chk("sof_beat", 128'(bus.sof), 128'(tb_beat == 0));
         chk("calc_eq_rel", 128'(bus.calculate), 128'd1);
         tb_beat = (tb_beat + 1) % 8;
      end else begin
         chk("sof_idle", 128'(bus.sof), 128'd0);
      end
      if (sreset) begin
         sb_q.delete();
         tb_beat = 0;
      end else if (bus.s_valid && bus.s_ready) begin
         sb_q.push_back(bus.s_data);
      end
   end

   task automatic do_reset();
      sreset = 1'b1;
      tick();
      sreset = 1'b0;
      @(negedge clk);
      chk("rst_s_ready", 128'(bus.s_ready), 128'd1);
      chk("rst_rel", 128'(bus.rel), 128'd0);
      chk("rst_samples", bus.samples, 128'd0);
      tick();
   endtask

   task automatic send_n(input int n, input int base);
      logic rdy;
      int   g;
      for (int i = 0; i < n; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 16'(base + i);
         g = 0;
         do begin
            @(negedge clk);
            rdy = bus.s_ready;
            tick();
            g++;
         end while (!rdy && g < 300);
         if (!rdy) chk("send_timeout", 128'd0, 128'd1);
      end
      bus.s_valid = 1'b0;
   endtask

   task automatic measure_run(input bit drop_on_acc, output int lat, output int run,
                              output logic [31:0] sof_mask, output int first_rdy);
      logic acc;
      lat = 0; run = 0; sof_mask = 32'd0; first_rdy = -1;
      @(negedge clk);
      while (!bus.rel && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!bus.rel) begin
         chk("rel_timeout", 128'd0, 128'd1);
      end else begin
         while (bus.rel && run < 32) begin
            if (bus.sof) sof_mask[run] = 1'b1;
            if (bus.s_ready && first_rdy < 0) first_rdy = run;
            acc = bus.s_valid && bus.s_ready;
            run++;
            tick();
            if (drop_on_acc && acc) bus.s_valid = 1'b0;
            @(negedge clk);
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, run, first_rdy;
      logic [31:0] sofm;
      logic [127:0] exp;
      n_tests = 0; n_fail = 0; tb_beat = 0;
      sreset = 1'b1; bus.s_valid = 1'b0; bus.s_data = 16'd0; bus.dft_ready = 1'b0;
      tick();
      do_reset();

      // Single frame, samples 0..63
      bus.dft_ready = 1'b1;
      send_n(64, 0);
      measure_run(1'b0, lat, run, sofm, first_rdy);
      chk("t1_latency", 128'(lat), 128'd0);
      chk("t1_run", 128'(run), 128'd8);
      chk("t1_sof_mask", 128'(sofm), 128'h1);
      exp = 128'd0;
      for (int k = 0; k < 8; k++) exp[16*(7-k) +: 16] = 16'(56 + k);
      tick();
      @(negedge clk);
      chk("t1_hold", bus.samples, exp);
      chk("t1_rel_low", 128'(bus.rel), 128'd0);
      tick();

      // Backpressure: both banks fill, sample 129 waits for frame 1 to finish
      do_reset();
      bus.dft_ready = 1'b0;
      send_n(128, 100);
      @(negedge clk);
      chk("t2_s_ready_low", 128'(bus.s_ready), 128'd0);
      chk("t2_no_rel", 128'(bus.rel), 128'd0);
      tick();
      bus.s_valid = 1'b1;
      bus.s_data  = 16'd500;
      bus.dft_ready = 1'b1;
      measure_run(1'b1, lat, run, sofm, first_rdy);
      chk("t2_latency", 128'(lat), 128'd1);
      chk("t2_run", 128'(run), 128'd16);
      chk("t2_sof_mask", 128'(sofm), 128'h0101);
      chk("t2_hold129", 128'(first_rdy), 128'd8);
      chk("t2_sb_left", 128'(sb_q.size()), 128'd1);
      bus.s_valid = 1'b0;

      // Sample 63 of bank B lands on the edge ending beat 7 of bank A
      do_reset();
      bus.dft_ready = 1'b0;
      send_n(64, 3000);
      send_n(56, 4000);
      @(negedge clk);
      chk("t3_no_rel", 128'(bus.rel), 128'd0);
      tick();
      bus.dft_ready = 1'b1;
      fork
         measure_run(1'b0, lat, run, sofm, first_rdy);
         begin
            tick();
            for (int i = 56; i < 64; i++) begin
               bus.s_valid = 1'b1;
               bus.s_data  = 16'(4000 + i);
               tick();
            end
            bus.s_valid = 1'b0;
         end
      join
      chk("t3_run", 128'(run), 128'd16);
      chk("t3_sof_mask", 128'(sofm), 128'h0101);
      chk("t3_sb_empty", 128'(sb_q.size()), 128'd0);
      @(negedge clk);
      chk("t3_s_ready", 128'(bus.s_ready), 128'd1);
      tick();

      // Reset during beat 3, then a clean frame
      do_reset();
      bus.dft_ready = 1'b1;
      send_n(64, 1000);
      tick(); tick(); tick();
      do_reset();
      send_n(64, 2000);
      measure_run(1'b0, lat, run, sofm, first_rdy);
      chk("t4_latency", 128'(lat), 128'd0);
      chk("t4_run", 128'(run), 128'd8);
      chk("t4_sof_mask", 128'(sofm), 128'h1);
      chk("t4_sb_empty", 128'(sb_q.size()), 128'd0);

`ifdef DFT64_PACK_STALL_CNT_EN
      do_reset();
      bus.dft_ready = 1'b0;
      send_n(128, 5000);
      @(negedge clk);
      chk("t5_stall_zero", 128'(stall_cnt), 128'd0);
      tick();
      bus.s_valid = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      bus.s_valid = 1'b0;
      @(negedge clk);
      chk("t5_stall_ten", 128'(stall_cnt), 128'd10);
      tick();
      do_reset();
      @(negedge clk);
      chk("t5_stall_clr", 128'(stall_cnt), 128'd0);
      tick();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/dft64_sample_packer.md
DFT64_SAMPLE_PACKER -- requirements
Module: dft64_sample_packer

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all logic on the rising edge.
REQ-002 SHALL have port sreset, input, 1, the synchronous active-high reset.
REQ-003 SHALL have port s_valid, input, 1, upstream sample valid.
REQ-004 SHALL have port s_data, input, 16, signed Q8.8 audio sample.
REQ-005 SHALL have port s_ready, output, 1, packer can accept a sample this cycle.
REQ-006 SHALL have port dft_ready, input, 1, downstream dft64 can take a new frame.
REQ-007 SHALL have port samples, output, 128, one beat of 8 samples; the oldest sample is in bits [127:112] and the newest in bits [15:0].
REQ-008 SHALL have port rel, output, 1, beat valid strobe for dft64.
REQ-009 SHALL have port calculate, output, 1, equal to rel.
REQ-010 SHALL have port sof, output, 1, high on beat 0 of each frame only.

Function
REQ-011 SHALL accept a sample when s_valid && s_ready at a rising edge; no other event accepts a sample.
REQ-012 SHALL store samples in two 64-sample banks (ping-pong) using a 6-bit write index and a 1-bit write-bank pointer.
REQ-013 SHALL, on accepting sample index 63, set full[wr_bank], toggle wr_bank and wrap the index to 0 on that same edge.
REQ-014 SHALL drive s_ready = !full[wr_bank], from registered state only.
REQ-015 SHALL implement FSM IDLE/BURST: IDLE->BURST when full[rd_bank] && dft_ready at an edge; BURST lasts exactly 8 cycles (beat 0..7) and ignores dft_ready; after beat 7, BURST->IDLE.
REQ-016 SHALL, at the end of beat 7, clear full[rd_bank] and toggle rd_bank.
REQ-017 SHALL register samples, rel, calculate and sof; in beat b, samples SHALL carry bank samples 8b..8b+7.
REQ-018 SHALL present beat 0 in the cycle after the edge that sets full, if dft_ready is high at that edge; minimum latency from accepting sample 63 to rel high is 1 cycle.
REQ-019 SHALL emit back-to-back frames with no gap only if the other bank is full at the edge ending beat 7; otherwise rel SHALL be low for at least one cycle.
REQ-020 SHALL let the clear of full[rd_bank] and the set of full[wr_bank] happen on the same edge without losing either event.
REQ-021 SHALL hold samples at its last value and drive rel/sof low in IDLE.
REQ-022 SHALL never reorder, duplicate or drop accepted samples; with both banks full, s_ready is low and upstream stalls.

Reset
REQ-023 SHALL, on an edge with sreset high, clear the indices, the bank pointers and both full flags; set FSM to IDLE; and zero samples, rel, calculate and sof.
REQ-024 SHALL abort a burst in progress when sreset is asserted mid-burst; rel SHALL be low in the cycle after that edge and partial frames SHALL be discarded.
REQ-025 SHALL drive s_ready high in the first cycle after reset deasserts.

Configuration
REQ-026 SHALL, with macro DFT64_PACK_STALL_CNT_EN defined, add port stall_cnt, output, 16.
REQ-027 SHALL, with DFT64_PACK_STALL_CNT_EN defined, increment stall_cnt on every edge where s_valid && !s_ready, saturating at 16'hFFFF; sreset clears it to 0.
REQ-028 SHALL, without DFT64_PACK_STALL_CNT_EN, omit the stall_cnt port and its counter entirely; all other behaviour is unchanged.

Verification
REQ-029 SHALL cover single frame: 64 continuous samples n=0..63 with value n, dft_ready=1 -> 8 consecutive rel cycles, sof only on the first; beat 0 = {16'd0,16'd1,...,16'd7}; beat 7 ends with 16'd63.
REQ-030 SHALL cover backpressure: dft_ready=0 while 128 samples are sent -> s_ready low after the 128th sample; sample 129 is held until beat 7 of frame 1 completes.
REQ-031 SHALL cover back-to-back frames: both banks full, then dft_ready=1 -> 16 consecutive rel cycles with sof at cycles 0 and 8.
REQ-032 SHALL cover simultaneous events: sample 63 of bank B accepted on the same edge as beat 7 of bank A -> both full flags correct and frame B follows with no gap.
REQ-033 SHALL cover reset mid-burst: sreset asserted during beat 3 -> rel low in the next cycle, s_ready high, and the next 64 samples form a clean frame.
REQ-034 SHALL cover stall counter (DFT64_PACK_STALL_CNT_EN defined): s_valid held 10 cycles with s_ready low -> stall_cnt = 10; sreset -> 0.
